pipe_ctrl: RTL and testbench

Central pipeline sequencer for the 5-stage MIPS core. It merges three sources of pipeline control into one set of per-stage enable, flush and bubble signals:
- the hazard unit's active-low stall;
- branch-taken from EX;
- the data-memory request/acknowledge handshake.

It also sequences halt/drain/resume, detects stall deadlock, and keeps saturating performance counters.

---
 rtl/pipe_ctrl_pkg.sv | 8 +
 rtl/pipe_ctrl_sat_counter.sv | 15 +
 rtl/pipe_ctrl.sv | 107 ++++++++++
 tb/tb_pipe_ctrl.sv | 151 +++++++++++++++
 4 files changed

// File: rtl/pipe_ctrl_pkg.sv
// pipe_ctrl_pkg: shared state encoding, parameter defaults and NOP encoding for the pipeline sequencer
package pipe_ctrl_pkg;
  typedef enum logic [1:0] {RUN, MEM_WAIT, DRAIN, HALTED} state_t;
  localparam int MAX_STALL_DEF = 15;
  localparam int DRAIN_CYCLES_DEF = 3;
  localparam int CNT_W_DEF = 16;
  localparam logic [31:0] NOP_INSTR = 32'h0000_0000;
endpackage

// File: rtl/pipe_ctrl_sat_counter.sv
// sat_counter: synchronous-clear counter that saturates at all-ones
module sat_counter #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clr,
  input  logic         inc,
  output logic [W-1:0] q
);
  logic [W-1:0] q_d, q_q;
  always_comb q_d = (rst || clr) ? '0 : (inc && !(&q_q)) ? q_q + W'(1) : q_q;
  always_ff @(posedge clk) q_q <= q_d;
  assign q = q_q;
endmodule

// File: rtl/pipe_ctrl.sv
// pipe_ctrl: merges hazard stall, branch flush and memory wait into per-stage enables, sequences halt/drain/resume, flags stall deadlock and counts stalls/flushes
module pipe_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter int MAX_STALL    = MAX_STALL_DEF,
  parameter int DRAIN_CYCLES = DRAIN_CYCLES_DEF,
  parameter int CNT_W        = CNT_W_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             hazard_stall_n,
  input  logic             branch_taken,
  input  logic             mem_req,
  input  logic             mem_ack,
  input  logic             halt_req,
  input  logic             resume,
  output logic             pc_en,
  output logic             ifid_en,
  output logic             idex_en,
  output logic             exmem_en,
  output logic             memwb_en,
  output logic             ifid_flush,
  output logic             idex_bubble,
  output logic             halted,
  output logic             deadlock,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt
);
  localparam int DW = $clog2(DRAIN_CYCLES + 1);
  localparam int SW = $clog2(MAX_STALL + 1);
  state_t state_d, state_q;
  logic [DW-1:0] dcnt_d, dcnt_q;
  logic [SW-1:0] cs_cnt;
  logic [4:0] en;
  logic mem_wait, frz, st_inc, cs_inc, cs_hold, hit, dl_d, dl_q;
  assign mem_wait = mem_req & ~mem_ack;
  assign frz = (state_q == MEM_WAIT) ? ~mem_ack : mem_wait;
  always_comb begin
    state_d = state_q;
    dcnt_d = dcnt_q;
    en = 5'b00000;
    ifid_flush = 1'b0;
    idex_bubble = 1'b0;
    st_inc = 1'b0;
    cs_inc = 1'b0;
    cs_hold = 1'b0;
    case (state_q)
      RUN, MEM_WAIT: begin
        if (frz) begin
          cs_hold = 1'b1;
          state_d = MEM_WAIT;
        end else begin
          state_d = RUN;
          cs_hold = (state_q == MEM_WAIT);
          if (branch_taken) begin
            en = 5'b11111;
            ifid_flush = 1'b1;
            idex_bubble = 1'b1;
          end else if (!hazard_stall_n) begin
            en = 5'b00111;
            idex_bubble = 1'b1;
            st_inc = 1'b1;
            cs_inc = (state_q == RUN);
          end else begin
            en = 5'b11111;
          end
          if (state_q == RUN && halt_req) begin
            state_d = DRAIN;
            dcnt_d = DW'(DRAIN_CYCLES - 1);
          end
        end
      end
      DRAIN: begin
        if (!mem_wait) begin
          en = {branch_taken, 4'b0111};
          ifid_flush = branch_taken;
          idex_bubble = 1'b1;
          state_d = (dcnt_q == '0) ? HALTED : DRAIN;
          dcnt_d = (dcnt_q == '0) ? dcnt_q : dcnt_q - DW'(1);
        end
      end
      default: state_d = resume ? RUN : HALTED;
    endcase
    if (rst) begin
      state_d = RUN;
      dcnt_d = '0;
      en = 5'b00000;
      ifid_flush = 1'b1;
      idex_bubble = 1'b1;
      st_inc = 1'b0;
      cs_inc = 1'b0;
    end
  end
  assign {pc_en, ifid_en, idex_en, exmem_en, memwb_en} = en;
  assign hit = cs_inc && (cs_cnt == SW'(MAX_STALL - 1));
  assign deadlock = ~rst & (dl_q | hit);
  assign dl_d = deadlock;
  assign halted = ~rst & (state_q == HALTED);
  always_ff @(posedge clk) begin
    state_q <= state_d;
    dcnt_q <= dcnt_d;
    dl_q <= dl_d;
  end
  sat_counter #(.W(CNT_W)) u_stall (.clk(clk), .rst(rst), .clr(1'b0), .inc(st_inc), .q(stall_cnt));
  sat_counter #(.W(CNT_W)) u_flush (.clk(clk), .rst(rst), .clr(1'b0), .inc(ifid_flush), .q(flush_cnt));
  sat_counter #(.W(SW)) u_consec (.clk(clk), .rst(rst), .clr(~cs_inc & ~cs_hold), .inc(cs_inc), .q(cs_cnt));
endmodule

// File: tb/tb_pipe_ctrl.sv
// tb_pipe_ctrl: directed scoreboard bench for pipe_ctrl
module tb_pipe_ctrl;
  localparam logic [8:0] C_RUN  = 9'b111110000;
  localparam logic [8:0] C_FRZ  = 9'b000000000;
  localparam logic [8:0] C_BR   = 9'b111111100;
  localparam logic [8:0] C_ST   = 9'b001110100;
  localparam logic [8:0] C_DR   = 9'b001110100;
  localparam logic [8:0] C_DRB  = 9'b101111100;
  localparam logic [8:0] C_RST  = 9'b000001100;
  localparam logic [8:0] C_HALT = 9'b000000010;
  logic clk = 1'b0;
  logic rst, hazard_stall_n, branch_taken, mem_req, mem_ack, halt_req, resume;
  logic pc_en, ifid_en, idex_en, exmem_en, memwb_en, ifid_flush, idex_bubble, halted, deadlock;
  logic [15:0] stall_cnt, flush_cnt;
  logic pc4, if4, id4, ex4, mw4, fl4, bb4, h4, d4;
  logic [3:0] s4, f4;
  logic [8:0] obs;
  logic [8:0] exp_q[$];
  logic dl = 1'b0;
  int cmp = 0;
  int mis = 0;
  pipe_ctrl dut (
    .clk(clk), .rst(rst), .hazard_stall_n(hazard_stall_n), .branch_taken(branch_taken),
    .mem_req(mem_req), .mem_ack(mem_ack), .halt_req(halt_req), .resume(resume),
    .pc_en(pc_en), .ifid_en(ifid_en), .idex_en(idex_en), .exmem_en(exmem_en), .memwb_en(memwb_en),
    .ifid_flush(ifid_flush), .idex_bubble(idex_bubble), .halted(halted), .deadlock(deadlock),
    .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
  );
  pipe_ctrl #(.CNT_W(4)) dut4 (
    .clk(clk), .rst(rst), .hazard_stall_n(hazard_stall_n), .branch_taken(branch_taken),
    .mem_req(mem_req), .mem_ack(mem_ack), .halt_req(halt_req), .resume(resume),
    .pc_en(pc4), .ifid_en(if4), .idex_en(id4), .exmem_en(ex4), .memwb_en(mw4),
    .ifid_flush(fl4), .idex_bubble(bb4), .halted(h4), .deadlock(d4),
    .stall_cnt(s4), .flush_cnt(f4)
  );
  assign obs = {pc_en, ifid_en, idex_en, exmem_en, memwb_en, ifid_flush, idex_bubble, halted, deadlock};
  always #5 clk = ~clk;
  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1, "watchdog");
  end
  task automatic step(input string tag, input logic [8:0] e);
    logic [8:0] x;
    exp_q.push_back(e | {8'b0, dl});
    @(negedge clk);
    x = exp_q.pop_front();
    cmp++;
    assert (obs === x) else begin
      mis++;
      $error("FAIL %s: observed %b expected %b", tag, obs, x);
    end
    @(posedge clk);
    #1;
  endtask
  task automatic chkc(input string tag, input int got, input int want);
    cmp++;
    assert (got === want) else begin
      mis++;
      $error("FAIL %s: observed %0d expected %0d", tag, got, want);
    end
  endtask
  initial begin
    rst = 1'b1; hazard_stall_n = 1'b1; branch_taken = 1'b0;
    mem_req = 1'b0; mem_ack = 1'b0; halt_req = 1'b0; resume = 1'b0;
    @(posedge clk); #1;
    step("rst_a", C_RST);
    step("rst_b", C_RST);
    chkc("rst_stall_cnt", int'(stall_cnt), 0);
    chkc("rst_flush_cnt", int'(flush_cnt), 0);
    rst = 1'b0;
    step("run_first", C_RUN);
    chkc("run_stall_cnt", int'(stall_cnt), 0);
    chkc("run_flush_cnt", int'(flush_cnt), 0);
    hazard_stall_n = 1'b0;
    repeat (3) step("hazard", C_ST);
    hazard_stall_n = 1'b1;
    chkc("hazard_stall_cnt", int'(stall_cnt), 3);
    step("hazard_end", C_RUN);
    mem_req = 1'b1;
    repeat (3) step("mem_wait", C_FRZ);
    mem_ack = 1'b1;
    step("mem_ack", C_RUN);
    mem_req = 1'b0; mem_ack = 1'b0;
    step("mem_after", C_RUN);
    mem_req = 1'b1; mem_ack = 1'b1;
    step("zero_wait", C_RUN);
    mem_req = 1'b0; mem_ack = 1'b0;
    step("zero_wait_after", C_RUN);
    branch_taken = 1'b1; hazard_stall_n = 1'b0; mem_req = 1'b1;
    step("sim_freeze_run", C_FRZ);
    step("sim_freeze_wait", C_FRZ);
    mem_ack = 1'b1;
    step("sim_ack_branch", C_BR);
    branch_taken = 1'b0; hazard_stall_n = 1'b1; mem_req = 1'b0; mem_ack = 1'b0;
    chkc("sim_flush_cnt", int'(flush_cnt), 1);
    chkc("sim_stall_cnt", int'(stall_cnt), 3);
    hazard_stall_n = 1'b0;
    repeat (14) step("dl_pre", C_ST);
    dl = 1'b1;
    step("dl_hit", C_ST);
    hazard_stall_n = 1'b1;
    step("dl_sticky", C_RUN);
    chkc("stall_cnt_18", int'(stall_cnt), 18);
    chkc("sat4_18", int'(s4), 15);
    hazard_stall_n = 1'b0;
    repeat (2) step("stall_more", C_ST);
    hazard_stall_n = 1'b1;
    chkc("stall_cnt_20", int'(stall_cnt), 20);
    chkc("sat4_20", int'(s4), 15);
    halt_req = 1'b1;
    step("halt_accept", C_RUN);
    halt_req = 1'b0;
    step("drain1", C_DR);
    branch_taken = 1'b1;
    step("drain2_branch", C_DRB);
    branch_taken = 1'b0;
    step("drain3", C_DR);
    step("halted", C_HALT);
    halt_req = 1'b1;
    step("halt_ignored", C_HALT);
    halt_req = 1'b0; resume = 1'b1;
    step("resume_pulse", C_HALT);
    resume = 1'b0;
    step("resumed_run", C_RUN);
    resume = 1'b1;
    step("resume_ignored", C_RUN);
    resume = 1'b0;
    halt_req = 1'b1;
    step("halt2_accept", C_RUN);
    halt_req = 1'b0;
    step("dm1", C_DR);
    mem_req = 1'b1;
    step("dm_wait1", C_FRZ);
    step("dm_wait2", C_FRZ);
    mem_ack = 1'b1;
    step("dm_ack", C_DR);
    mem_req = 1'b0; mem_ack = 1'b0;
    step("dm3", C_DR);
    step("dm_halted", C_HALT);
    rst = 1'b1; dl = 1'b0;
    step("rst_from_halt", C_RST);
    chkc("rst2_stall_cnt", int'(stall_cnt), 0);
    chkc("rst2_flush_cnt", int'(flush_cnt), 0);
    chkc("rst2_sat4", int'(s4), 0);
    rst = 1'b0;
    step("post_rst_run", C_RUN);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp, mis);
    $finish;
  end
endmodule
